// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle CPU controller: state encoding,
// opcode constants, datapath select codes and the control-word struct.
package mcpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One control word per cycle, grouped so the top can gate strobes as a unit
    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       jal;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J, OP_JAL: op_legal = 1'b1;
            default:                      op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_out_decode.sv
// Combinational control-word decode from current state, opcode and the
// ALU zero flag. mem_ok marks the cycle in which a memory access completes
// (tied high when memory is single-cycle).
module mcpu_out_decode
    import mcpu_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ok,
    output ctrl_t       ctl
);

    // Decode per state; everything not explicitly driven stays 0
    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.iord      = 1'b0;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = mem_ok;
                ctl.pc_write  = mem_ok;
            end
            S_DECODE: begin
                // Branch target is computed here while the opcode is examined
                ctl.alu_src_b  = SRCB_IMM_SH;
                ctl.alu_op     = ALU_ADD;
                ctl.illegal_op = !op_legal(opcode);
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = SRCB_RT;
                        ctl.alu_op    = ALU_FUNCT;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = SRCB_IMM;
                        ctl.alu_op    = ALU_ADD;
                    end
                    OP_BEQ, OP_BNE: begin
                        ctl.alu_src_a  = 1'b1;
                        ctl.alu_src_b  = SRCB_RT;
                        ctl.alu_op     = ALU_SUB;
                        ctl.pc_source  = PCSRC_ALUOUT;
                        ctl.pc_write   = zero ^ (opcode == OP_BNE);
                        ctl.instr_done = 1'b1;
                    end
                    OP_J, OP_JAL: begin
                        ctl.pc_source  = PCSRC_JUMP;
                        ctl.pc_write   = 1'b1;
                        ctl.instr_done = 1'b1;
                        ctl.jal        = (opcode == OP_JAL);
                        ctl.reg_write  = (opcode == OP_JAL);
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctl.iord       = 1'b1;
                ctl.mem_read   = (opcode == OP_LW);
                ctl.mem_write  = (opcode == OP_SW);
                ctl.instr_done = (opcode == OP_SW) && mem_ok;
            end
            S_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = (opcode == OP_RTYPE);
                ctl.mem_to_reg = (opcode == OP_LW);
                ctl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: holds the state register and next-state logic,
// and gates the decoded control word with the run enable.
// Build option: define MCTRL_MEM_WAIT_EN to stall FETCH and MEM on mem_ready;
// otherwise mem_ready is ignored and memory is single-cycle.
module multicycle_ctrl
    import mcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       jal,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [2:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctl;
    logic   mem_ok;

`ifdef MCTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_ok           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    // State register; reset forces IDLE, whose decode is all-zero outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: every transition requires en; memory states wait on mem_ok
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S_IDLE:   state_d = S_FETCH;
                S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
                S_DECODE: state_d = op_legal(opcode) ? S_EXEC : S_FETCH;
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE, OP_ADDI: state_d = S_WB;
                        OP_LW, OP_SW:      state_d = S_MEM;
                        default:           state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ok) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
                end
                S_WB:     state_d = S_FETCH;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    mcpu_out_decode u_decode (
        .state  (state_q),
        .opcode (opcode),
        .zero   (zero),
        .mem_ok (mem_ok),
        .ctl    (ctl)
    );

    // While frozen, writes and the per-instruction pulses are suppressed so
    // a held state cannot repeat a side effect
    assign ir_write   = ctl.ir_write   & en;
    assign pc_write   = ctl.pc_write   & en;
    assign mem_write  = ctl.mem_write  & en;
    assign reg_write  = ctl.reg_write  & en;
    assign illegal_op = ctl.illegal_op & en;
    assign instr_done = ctl.instr_done & en;

    assign iord       = ctl.iord;
    assign mem_read   = ctl.mem_read;
    assign reg_dst    = ctl.reg_dst;
    assign mem_to_reg = ctl.mem_to_reg;
    assign jal        = ctl.jal;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_op     = ctl.alu_op;
    assign pc_source  = ctl.pc_source;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Output vector layout (17..0):
// ir_write pc_write iord mem_read mem_write reg_write reg_dst mem_to_reg jal
// alu_src_a alu_src_b[2] alu_op[2] pc_source[2] illegal_op instr_done
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       ir_write, pc_write, iord, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, jal, alu_src_a, illegal_op, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [2:0] state;
    logic [17:0] outs;

    int checks = 0;
    int passes = 0;

    localparam logic [17:0] O_ZERO       = 18'b0;
    localparam logic [17:0] O_FETCH      = 18'b1_1_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] O_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] O_DEC        = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] O_DEC_ILL    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [17:0] O_EX_MEMOP   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] O_EX_R       = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] O_EX_BR_TK   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] O_EX_BR_NT   = 18'b0_0_0_0_0_0_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] O_EX_BR_FRZ  = 18'b0_0_0_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [17:0] O_EX_J       = 18'b0_1_0_0_0_0_0_0_0_0_00_00_10_0_1;
    localparam logic [17:0] O_EX_JAL     = 18'b0_1_0_0_0_1_0_0_1_0_00_00_10_0_1;
    localparam logic [17:0] O_MEM_LW     = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_MEM_SW     = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
    localparam logic [17:0] O_MEM_SW_W   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] O_WB_LW      = 18'b0_0_0_0_0_1_0_1_0_0_00_00_00_0_1;
    localparam logic [17:0] O_WB_R       = 18'b0_0_0_0_0_1_1_0_0_0_00_00_00_0_1;
    localparam logic [17:0] O_WB_I       = 18'b0_0_0_0_0_1_0_0_0_0_00_00_00_0_1;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .jal        (jal),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (illegal_op),
        .instr_done (instr_done),
        .state      (state)
    );

    assign outs = {ir_write, pc_write, iord, mem_read, mem_write, reg_write,
                   reg_dst, mem_to_reg, jal, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal_op, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset holds IDLE with zero outputs; first FETCH on first edge with en=1
    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({state, outs} !== {3'd0, O_ZERO})
            $display("FAIL reset_hold: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_ZERO);
        else passes++;
        en = 1'b1; opcode = 6'b100011;
        @(negedge clk);
        checks++;
        if ({state, outs} !== {3'd0, O_ZERO})
            $display("FAIL reset_hold_en: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_ZERO);
        else passes++;
        step();
        en = 1'b0; rst_n = 1'b1;
        step();
        checks++;
        if (state !== 3'd0)
            $display("FAIL idle_no_en: state=%0d, expected 0", state);
        else passes++;
        en = 1'b1;
        step();
        checks++;
        if ({state, outs} !== {3'd1, O_FETCH})
            $display("FAIL first_fetch: state=%0d outs=%b, expected state=1 outs=%b", state, outs, O_FETCH);
        else passes++;
    endtask

    task automatic test_lw();
        logic [2:0]  es [5];
        logic [17:0] eo [5];
        int dones = 0;
        es = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        eo = '{O_FETCH, O_DEC, O_EX_MEMOP, O_MEM_LW, O_WB_LW};
        opcode = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({state, outs} !== {es[i], eo[i]})
                $display("FAIL lw_cycle%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
            else passes++;
            if (instr_done === 1'b1) dones++;
            step();
        end
        checks++;
        if (dones != 1) $display("FAIL lw_done_count: got %0d pulses, expected 1", dones);
        else passes++;
        checks++;
        if (state !== 3'd1) $display("FAIL lw_latency: state=%0d, expected 1", state);
        else passes++;
    endtask

    task automatic test_branch();
        logic [5:0]  ops [3];
        logic        zs  [3];
        logic [17:0] ex  [3];
        ops = '{6'b000100, 6'b000101, 6'b000100};
        zs  = '{1'b1, 1'b1, 1'b0};
        ex  = '{O_EX_BR_TK, O_EX_BR_NT, O_EX_BR_NT};
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k]; zero = zs[k];
            @(negedge clk);
            checks++;
            if ({state, outs} !== {3'd1, O_FETCH})
                $display("FAIL br%0d_fetch: state=%0d outs=%b, expected state=1 outs=%b", k, state, outs, O_FETCH);
            else passes++;
            step();
            step();
            checks++;
            if ({state, outs} !== {3'd3, ex[k]})
                $display("FAIL br%0d_exec: state=%0d outs=%b, expected state=3 outs=%b", k, state, outs, ex[k]);
            else passes++;
            step();
            checks++;
            if (state !== 3'd1) $display("FAIL br%0d_latency: state=%0d, expected 1", k, state);
            else passes++;
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [5:0]  ops [2];
        logic [17:0] ex  [2];
        ops = '{6'b000011, 6'b000010};
        ex  = '{O_EX_JAL, O_EX_J};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            step();
            checks++;
            if ({state, outs} !== {3'd2, O_DEC})
                $display("FAIL jmp%0d_decode: state=%0d outs=%b, expected state=2 outs=%b", k, state, outs, O_DEC);
            else passes++;
            step();
            checks++;
            if ({state, outs} !== {3'd3, ex[k]})
                $display("FAIL jmp%0d_exec: state=%0d outs=%b, expected state=3 outs=%b", k, state, outs, ex[k]);
            else passes++;
            step();
            checks++;
            if (state !== 3'd1) $display("FAIL jmp%0d_latency: state=%0d, expected 1", k, state);
            else passes++;
        end
    endtask

    task automatic test_rtype_addi();
        logic [5:0]  ops [2];
        logic [17:0] exo [2];
        logic [17:0] wbo [2];
        ops = '{6'b000000, 6'b001000};
        exo = '{O_EX_R, O_EX_MEMOP};
        wbo = '{O_WB_R, O_WB_I};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            step();
            step();
            checks++;
            if ({state, outs} !== {3'd3, exo[k]})
                $display("FAIL alu%0d_exec: state=%0d outs=%b, expected state=3 outs=%b", k, state, outs, exo[k]);
            else passes++;
            step();
            checks++;
            if ({state, outs} !== {3'd5, wbo[k]})
                $display("FAIL alu%0d_wb: state=%0d outs=%b, expected state=5 outs=%b", k, state, outs, wbo[k]);
            else passes++;
            step();
            checks++;
            if (state !== 3'd1) $display("FAIL alu%0d_latency: state=%0d, expected 1", k, state);
            else passes++;
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111;
        step();
        checks++;
        if ({state, outs} !== {3'd2, O_DEC_ILL})
            $display("FAIL illegal_decode: state=%0d outs=%b, expected state=2 outs=%b", state, outs, O_DEC_ILL);
        else passes++;
        step();
        checks++;
        if ({state, illegal_op} !== {3'd1, 1'b0})
            $display("FAIL illegal_return: state=%0d illegal_op=%b, expected state=1 illegal_op=0", state, illegal_op);
        else passes++;
    endtask

    // Freeze mid-EXEC of a taken branch: state held, strobes and pulse low
    task automatic test_en_hold();
        opcode = 6'b000100; zero = 1'b1;
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({state, outs} !== {3'd3, O_EX_BR_FRZ})
                $display("FAIL hold%0d: state=%0d outs=%b, expected state=3 outs=%b", i, state, outs, O_EX_BR_FRZ);
            else passes++;
            step();
        end
        en = 1'b1;
        #1;
        checks++;
        if ({state, outs} !== {3'd3, O_EX_BR_TK})
            $display("FAIL hold_release: state=%0d outs=%b, expected state=3 outs=%b", state, outs, O_EX_BR_TK);
        else passes++;
        step();
        zero = 1'b0;
        checks++;
        if (state !== 3'd1) $display("FAIL hold_resume: state=%0d, expected 1", state);
        else passes++;
    endtask

    // Asynchronous reset in EXEC of lw, then restart
    task automatic test_reset_mid();
        opcode = 6'b100011;
        step();
        step();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({state, outs} !== {3'd0, O_ZERO})
            $display("FAIL midreset_async: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_ZERO);
        else passes++;
        step();
        checks++;
        if ({state, outs} !== {3'd0, O_ZERO})
            $display("FAIL midreset_held: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_ZERO);
        else passes++;
        rst_n = 1'b1;
        step();
        checks++;
        if ({state, outs} !== {3'd1, O_FETCH})
            $display("FAIL midreset_refetch: state=%0d outs=%b, expected state=1 outs=%b", state, outs, O_FETCH);
        else passes++;
    endtask

`ifdef MCTRL_MEM_WAIT_EN
    task automatic test_mem_wait();
        opcode = 6'b101011; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({state, outs} !== {3'd1, O_FETCH_WAIT})
                $display("FAIL fetch_wait%0d: state=%0d outs=%b, expected state=1 outs=%b", i, state, outs, O_FETCH_WAIT);
            else passes++;
            step();
        end
        mem_ready = 1'b1;
        step();
        step();
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({state, outs} !== {3'd4, O_MEM_SW_W})
                $display("FAIL mem_wait%0d: state=%0d outs=%b, expected state=4 outs=%b", i, state, outs, O_MEM_SW_W);
            else passes++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, outs} !== {3'd4, O_MEM_SW})
            $display("FAIL mem_wait_done: state=%0d outs=%b, expected state=4 outs=%b", state, outs, O_MEM_SW);
        else passes++;
        step();
        checks++;
        if (state !== 3'd1) $display("FAIL mem_wait_exit: state=%0d, expected 1", state);
        else passes++;
    endtask
`else
    task automatic test_mem_ready_ignored();
        logic [2:0]  es [4];
        logic [17:0] eo [4];
        es = '{3'd1, 3'd2, 3'd3, 3'd4};
        eo = '{O_FETCH, O_DEC, O_EX_MEMOP, O_MEM_SW};
        opcode = 6'b101011; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({state, outs} !== {es[i], eo[i]})
                $display("FAIL sw_cycle%0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, outs, es[i], eo[i]);
            else passes++;
            step();
        end
        checks++;
        if (state !== 3'd1) $display("FAIL sw_latency: state=%0d, expected 1", state);
        else passes++;
        mem_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_jump();
        test_rtype_addi();
        test_illegal();
        test_en_hold();
`ifdef MCTRL_MEM_WAIT_EN
        test_mem_wait();
`else
        test_mem_ready_ignored();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- en, in, 1: run enable; low freezes the FSM in its current state.
- opcode, in, 6: instruction opcode, valid from DECODE onward.
- zero, in, 1: ALU zero flag.
- mem_ready, in, 1: memory access complete.
- ir_write, out, 1: instruction register load.
- pc_write, out, 1: PC load.
- iord, out, 1: memory address select (0 = PC, 1 = ALU out).
- mem_read, out, 1: memory read strobe.
- mem_write, out, 1: memory write strobe.
- reg_write, out, 1: register file write.
- reg_dst, out, 1: write register select (1 = rd, 0 = rt).
- mem_to_reg, out, 1: write data select (1 = memory).
- jal, out, 1: write $31 with PC+4.
- alu_src_a, out, 1: ALU A select (0 = PC, 1 = rs).
- alu_src_b, out, 2: ALU B select (00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2).
- alu_op, out, 2: 00 add, 01 sub, 10 funct.
- pc_source, out, 2: 00 ALU result, 01 ALU out register, 10 jump target.
- illegal_op, out, 1: one-cycle pulse on an unknown opcode.
- instr_done, out, 1: one-cycle pulse in the final state of each instruction.
- state, out, 3: current state encoding.

Function
REQ-002 The FSM SHALL have states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
REQ-003 The FSM SHALL move IDLE->FETCH on en=1; every other transition occurs only when en=1.
REQ-004 In FETCH the block SHALL assert mem_read, ir_write, pc_write, alu_src_b=01, alu_op=00, pc_source=00, iord=0, then move to DECODE.
REQ-005 In DECODE the block SHALL assert alu_src_b=11, alu_op=00 (branch target precompute), then move to EXEC.
REQ-006 The supported opcodes SHALL be: R=000000, addi=001000, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, jal=000011.
REQ-007 In EXEC for R-type the block SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to WB.
REQ-008 In EXEC for addi, lw and sw the block SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; addi then goes to WB, lw/sw go to MEM.
REQ-009 In EXEC for beq/bne the block SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=(zero XOR bne) and instr_done=1, then go to FETCH.
REQ-010 In EXEC for j/jal the block SHALL drive pc_source=10, pc_write=1 and instr_done=1; jal additionally asserts jal=1 and reg_write=1; then go to FETCH.
REQ-011 In MEM the block SHALL drive iord=1, with mem_read=1 for lw or mem_write=1 for sw; lw then goes to WB, while sw asserts instr_done and goes to FETCH.
REQ-012 In WB the block SHALL drive reg_write=1, with reg_dst=1 for R-type and mem_to_reg=1 for lw, assert instr_done, then go to FETCH.
REQ-013 On an unknown opcode in DECODE the block SHALL pulse illegal_op for one cycle and return to FETCH, with no write strobes asserted.
REQ-014 Instruction latency in cycles SHALL be: lw 5; R, addi, sw 4; beq, bne, j, jal 3.
REQ-015 Outputs SHALL be combinational from state and opcode only, except pc_write in EXEC for branches, which also depends on zero; undriven outputs are 0.
REQ-016 With en=0 the block SHALL hold its state and force all write strobes (ir_write, pc_write, mem_write, reg_write) to 0.

Reset
REQ-017 While rst_n=0 the state SHALL be IDLE and all outputs SHALL be 0, including mid-instruction.
REQ-018 After rst_n rises, the first FETCH SHALL occur on the first clock edge with en=1.

Configuration
REQ-019 With MCTRL_MEM_WAIT_EN defined, FETCH and MEM SHALL hold their state and strobes until mem_ready=1; ir_write/pc_write in FETCH and instr_done in sw MEM assert only in the mem_ready cycle.
REQ-020 Without MCTRL_MEM_WAIT_EN, the mem_ready port SHALL remain present but be ignored, and memory SHALL be treated as single-cycle.

Structure
REQ-021 The state encoding, opcode constants, and alu_op/alu_src_b/pc_source codes SHALL live in a shared package mcpu_pkg.
REQ-022 Output decoding SHALL be a sub-module mcpu_out_decode (state, opcode, zero -> strobes); the FSM register stays in multicycle_ctrl.

Verification
REQ-023 Reset mid-EXEC of lw -> state=0 and all outputs 0 immediately; after release with en=1, FETCH on the next edge.
REQ-024 opcode=100011 with mem_ready=1 -> states 1,2,3,4,5,1; reg_write=1 and mem_to_reg=1 only in WB; instr_done pulses once.
REQ-025 beq (000100) with zero=1 -> pc_write=1, pc_source=01 in EXEC; bne (000101) with zero=1 -> pc_write=0; both take 3 cycles.
REQ-026 jal (000011) -> EXEC drives pc_source=10, jal=1, reg_write=1, pc_write=1.
REQ-027 opcode=111111 -> illegal_op pulses in DECODE, next state FETCH, zero write strobes.
REQ-028 With MCTRL_MEM_WAIT_EN, sw and mem_ready low for 3 cycles in MEM -> MEM held 4 cycles, mem_write high throughout, instr_done in the 4th cycle only; en=0 mid-EXEC holds state with strobes low.
